// File: rtl/fetch_queue.sv
// Fetch stage: PC generation, one-cycle-latency imem reads, DEPTH-entry {pc, inst} queue to decode.
// Optional macro FETCH_BYPASS_EN presents a live response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = PW + 2;
  localparam logic [XLEN-1:0] FAULT_INST = XLEN'(32'hbadbadff);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_stale_q, inflight_stale_d;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] inst_mem_q [DEPTH];

  logic            fifo_nonempty;
  logic            resp_live;
  logic            bypass;
  logic            pop;
  logic            pop_fifo;
  logic            push;
  logic            issue;
  logic [LW-1:0]   level;

  // Low redirect bits only encode alignment and are dropped.
  logic            unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign fifo_nonempty = (count_q != '0);
  assign resp_live     = inflight_q && !inflight_stale_q && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = !fifo_nonempty && resp_live;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = fifo_nonempty || bypass;
  assign pop       = out_valid && out_ready;
  assign pop_fifo  = fifo_nonempty && out_ready;
  assign push      = resp_live && !(bypass && out_ready);

  // Slots committed after this cycle: stored entries plus the read in flight, minus the one leaving.
  assign level = LW'(count_q) + LW'(inflight_q) - LW'(pop);
  assign issue = !reset && !redirect_valid && (level < LW'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign occupancy = count_q;

  always_comb begin
    out_pc   = '0;
    out_inst = NOP_INST;
    if (bypass) begin
      out_pc   = inflight_pc_q;
      out_inst = imem_rdata;
    end else if (fifo_nonempty) begin
      out_pc   = pc_mem_q[rd_ptr_q];
      out_inst = inst_mem_q[rd_ptr_q];
    end
  end

  assign out_fault = out_valid && (out_inst == FAULT_INST);

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    inflight_d       = inflight_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_stale_d = inflight_stale_q;
    if (redirect_valid) begin
      fetch_pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_d         = '0;
      wr_ptr_d         = '0;
      count_d          = '0;
      inflight_d       = 1'b0;
      inflight_stale_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q + PW'(pop_fifo);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      count_d    = count_q + CW'(push) - CW'(pop_fifo);
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d    = fetch_pc_q;
        inflight_stale_d = 1'b0;
        fetch_pc_d       = fetch_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_stale_q <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_stale_q <= inflight_stale_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH=4): per-cycle vector table plus a throughput/stall sequence.
module tb_fetch_queue;

  localparam logic [31:0] P0         = 32'h0100_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] FAULT_ADDR = 32'h0100_0008;
  localparam logic [31:0] T1         = 32'h0200_0000;
  localparam logic [31:0] T2         = 32'h0100_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic [2:0]  occupancy;

  int tests = 0;
  int fails = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    if (a == FAULT_ADDR) return 32'hbadbadff;
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // Instruction memory with exactly one cycle of read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_fn(imem_addr);
  end

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  occ;
    logic        flt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic rv, logic [31:0] rpc, logic rdy,
                              logic req, logic [31:0] addr, logic vld,
                              logic [31:0] pc, int occ, logic flt);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    v.occ = 3'(occ); v.flt = flt;
    return v;
  endfunction

  function automatic logic [31:0] p(int n);
    return P0 + 32'(4 * n);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst rv rpc           rdy req addr      vld pc      occ flt
    // reset, then free-running with out_ready=1, then redirect with pop + response in same cycle
    vq.push_back(mk(1, 0, 0,            1,  0, P0,       0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(0),     0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(1),     0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(2),     1, p(0),    1, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(3),     1, p(1),    1, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(4),     1, p(2),    1, 1));
    vq.push_back(mk(0, 1, 32'h0200_0002, 1, 0, p(5),     1, p(3),    1, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, T1,       0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, T1 + 4,   0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, T1 + 8,   1, T1,      1, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, T1 + 12,  1, T1 + 4,  1, 0));
    // mid-stream reset, then decode stalled for 10 cycles, then released
    vq.push_back(mk(1, 0, 0,            0,  0, P0,       0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            0,  1, p(0),     0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            0,  1, p(1),     0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            0,  1, p(2),     1, p(0),    1, 0));
    vq.push_back(mk(0, 0, 0,            0,  1, p(3),     1, p(0),    2, 0));
    vq.push_back(mk(0, 0, 0,            0,  0, p(4),     1, p(0),    3, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 0,          0,  0, p(4),     1, p(0),    4, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(4),     1, p(0),    4, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(5),     1, p(1),    3, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(6),     1, p(2),    3, 1));
    vq.push_back(mk(0, 0, 0,            1,  1, p(7),     1, p(3),    3, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, p(8),     1, p(4),    3, 0));
    // reset with three entries and a read in flight; then redirect with two queued + one in flight
    vq.push_back(mk(1, 0, 0,            0,  0, P0,       0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            0,  1, p(0),     0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            0,  1, p(1),     0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            0,  1, p(2),     1, p(0),    1, 0));
    vq.push_back(mk(0, 1, 32'h0100_0103, 0, 0, p(3),     1, p(0),    2, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, T2,       0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, T2 + 4,   0, 0,       0, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, T2 + 8,   1, T2,      1, 0));
    vq.push_back(mk(0, 0, 0,            1,  1, T2 + 12,  1, T2 + 4,  1, 0));

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      reset          = vq[i].rst;
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      out_ready      = vq[i].rdy;
      @(negedge clk);
      chk("imem_req",  i, 32'(imem_req),  32'(vq[i].req));
      chk("imem_addr", i, imem_addr,      vq[i].addr);
      chk("out_valid", i, 32'(out_valid), 32'(vq[i].vld));
      chk("out_pc",    i, out_pc,         vq[i].pc);
      chk("out_inst",  i, out_inst,       vq[i].vld ? mem_fn(vq[i].pc) : NOP);
      chk("out_fault", i, 32'(out_fault), 32'(vq[i].flt));
      chk("occupancy", i, 32'(occupancy), 32'(vq[i].occ));
    end

    // Throughput after reset: first entry two cycles after release, then one per cycle; one stall cycle holds the entry.
    @(posedge clk);
    #1;
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    begin
      int lat;
      logic [31:0] exp_pc;
      lat = -1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (out_valid) begin
          lat = k;
          break;
        end
        @(posedge clk);
        #1;
      end
      chk("first_latency", 100, 32'(lat), 32'd2);
      exp_pc = P0;
      for (int k = 0; k < 12; k++) begin
        chk("stream_valid", 100 + k, 32'(out_valid), 32'd1);
        chk("stream_pc",    100 + k, out_pc, exp_pc);
        chk("stream_fault", 100 + k, 32'(out_fault), 32'(exp_pc == FAULT_ADDR));
        if (out_ready) exp_pc = exp_pc + 4;
        @(posedge clk);
        #1;
        out_ready = (k != 4);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
